mdr_hs: RTL and testbench

MDR_HS -- requirements
Module: mdr_hs

---
 rtl/mdr_hs_if.sv | 27 ++
 rtl/mdr_hs.sv | 146 ++++++++++++++
 tb/tb_mdr_hs.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mdr_hs_if.sv
// Memory-side handshake bundle for mdr_hs.
// master: the register block issuing transfers; slave: the memory answering them.
interface mdr_hs_if #(
  parameter int DATA_W = 8
) ();
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mdr_hs.sv
// Memory data register with a req/ready memory handshake.
// Commands (priority read > load > write) are accepted only while idle; a
// transfer holds mem_req high until mem_ready is sampled.
// Optional feature: define MDR_HS_TIMEOUT_EN to abort a transfer after
// WAIT_MAX consecutive wait edges without mem_ready (one-cycle err pulse).
module mdr_hs #(
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] C_bus,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err,
  mdr_hs_if.master          mem
);

  // Wait limit must fit the 8-bit wait counter.
  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("mdr_hs: WAIT_MAX out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              busy_q;

`ifdef MDR_HS_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Next-state and next-output decode for the transfer FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
`ifdef MDR_HS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (read) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = RD_WAIT;
`ifdef MDR_HS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (load) begin
          data_d = C_bus;
        end else if (write) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          wdata_d = data_q;
          state_d = WR_WAIT;
`ifdef MDR_HS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Commands are ignored while waiting; completion beats timeout.
        if (mem.mem_ready) begin
          if (state_q == RD_WAIT) data_d = mem.mem_rdata;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
`ifdef MDR_HS_TIMEOUT_EN
          if (cnt_q == WAIT_LAST) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MDR_HS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= (state_d != IDLE);
`ifdef MDR_HS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign data_out      = data_q;
  assign busy          = busy_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;
`ifdef MDR_HS_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_hs.sv
// Scoreboard bench for mdr_hs (DATA_W=8, WAIT_MAX=4). Stimulus pushes the
// expected post-edge state tagged with its edge number; the monitor pops and
// compares on the falling edge. The timeout scenario follows the macro.
module tb_mdr_hs;

  logic       clk;
  logic       rst_n;
  logic       load, read, write;
  logic [7:0] C_bus;
  logic [7:0] data_out;
  logic       busy, err;

  mdr_hs_if #(.DATA_W(8)) mem_bus ();

  mdr_hs #(.DATA_W(8), .WAIT_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .read     (read),
    .write    (write),
    .C_bus    (C_bus),
    .data_out (data_out),
    .busy     (busy),
    .err      (err),
    .mem      (mem_bus)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] dout;
    logic [7:0] wdata;
    logic       busy;
    logic       req;
    logic       we;
    logic       err;
    logic       all;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: value k means k rising edges have occurred.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs n edges from now. we is compared while a transfer is
  // expected; wdata only for writes; 'all' forces both (reset checks).
  task automatic expect_st(input string name, input int n, input logic [7:0] dout,
                           input logic bsy, input logic req, input logic we,
                           input logic [7:0] wdata, input logic er, input logic all);
    exp_t e;
    e.name = name; e.cyc = cyc + n; e.dout = dout; e.wdata = wdata;
    e.busy = bsy; e.req = req; e.we = we; e.err = er; e.all = all;
    sb.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry due at this edge count.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [19:0] act, exp, mask;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check({e.name, "_stale"}, 32'(cyc), 32'(e.cyc));
      end else begin
        act  = {data_out, mem_bus.mem_wdata, busy, mem_bus.mem_req, mem_bus.mem_we, err};
        exp  = {e.dout, e.wdata, e.busy, e.req, e.we, e.err};
        mask = {8'hFF, ((e.req && e.we) || e.all) ? 8'hFF : 8'h00,
                1'b1, 1'b1, (e.req || e.all), 1'b1};
        check(e.name, 32'(act & mask), 32'(exp & mask));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] d_now;

  initial begin
    rst_n = 1'b0; load = 1'b1; read = 1'b0; write = 1'b0; C_bus = 8'hFF;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 8'h00;
    step(); step();
    // Load asserted during reset must be discarded.
    load = 1'b0;
    expect_st("reset", 0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    rst_n = 1'b1;

    // Load then read with ready three edges after the command.
    load = 1'b1; C_bus = 8'hA5;
    expect_st("load", 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0);
    step(); load = 1'b0;
    read = 1'b1;
    expect_st("rd_issue", 1, 8'hA5, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    expect_st("rd_wait1", 1, 8'hA5, 1, 1, 0, 8'h00, 0, 0);
    step();
    expect_st("rd_wait2", 1, 8'hA5, 1, 1, 0, 8'h00, 0, 0);
    step();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'h3C;
    expect_st("rd_done", 1, 8'h3C, 0, 0, 0, 8'h00, 0, 0);
    step();
    // mem_ready in IDLE is ignored.
    mem_bus.mem_rdata = 8'h77;
    expect_st("idle_ready", 1, 8'h3C, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0;

    // Read beats load; commands while busy are ignored.
    load = 1'b1; read = 1'b1; C_bus = 8'h11;
    expect_st("rd_wins", 1, 8'h3C, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0; C_bus = 8'h22; write = 1'b1;
    expect_st("busy_cmds", 1, 8'h3C, 1, 1, 0, 8'h00, 0, 0);
    step(); load = 1'b0; write = 1'b0;
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'h5A;
    expect_st("rd2_done", 1, 8'h5A, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0;

    // Write issued on the first idle edge; C_bus moves while busy.
    write = 1'b1;
    expect_st("wr_issue", 1, 8'h5A, 1, 1, 1, 8'h5A, 0, 0);
    step(); write = 1'b0; load = 1'b1; C_bus = 8'h99;
    expect_st("wr_wait", 1, 8'h5A, 1, 1, 1, 8'h5A, 0, 0);
    step(); mem_bus.mem_ready = 1'b1; C_bus = 8'h66;
    expect_st("wr_done", 1, 8'h5A, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0; load = 1'b0;

`ifdef MDR_HS_TIMEOUT_EN
    // Timeout after the 4th wait edge, err for exactly one cycle.
    read = 1'b1;
    expect_st("to_issue", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_st("to_wait", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
      step();
    end
    expect_st("to_err", 1, 8'h5A, 0, 0, 0, 8'h00, 1, 0);
    step();
    expect_st("to_err_clr", 1, 8'h5A, 0, 0, 0, 8'h00, 0, 0);
    step();
    // Completion on the would-be timeout edge wins.
    read = 1'b1;
    expect_st("race_issue", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_st("race_wait", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
      step();
    end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'hE7;
    expect_st("race_done", 1, 8'hE7, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0;
    d_now = 8'hE7;
`else
    // No timeout: wait indefinitely for mem_ready.
    read = 1'b1;
    expect_st("long_issue", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    for (int i = 0; i < 300; i++) begin
      expect_st("long_wait", 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0);
      step();
    end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'hC3;
    expect_st("long_done", 1, 8'hC3, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0;
    d_now = 8'hC3;
`endif

    // Reset during RD_WAIT, even with mem_ready present: abandoned silently.
    read = 1'b1;
    expect_st("rst_issue", 1, d_now, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    rst_n = 1'b0; mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'hAA;
    expect_st("mid_reset", 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    step(); rst_n = 1'b1; mem_bus.mem_ready = 1'b0;
    expect_st("post_reset", 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    step();
    read = 1'b1;
    expect_st("rd3_issue", 1, 8'h00, 1, 1, 0, 8'h00, 0, 0);
    step(); read = 1'b0;
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 8'h4B;
    expect_st("rd3_done", 1, 8'h4B, 0, 0, 0, 8'h00, 0, 0);
    step(); mem_bus.mem_ready = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
